// File: rtl/regfile_param.sv
// Parametrised register file with a per-register busy scoreboard and a clear-sweep FSM.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_param #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                             clock,
  input  logic                             ctrl_reset_n,
  input  logic                             ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0]            data_writeReg,
  input  logic                             ctrl_reserveEnable,
  input  logic [ADDR_WIDTH-1:0]            ctrl_reserveReg,
  input  logic                             ctrl_clear,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   ctrl_readReg,
  output logic [NUM_READ*DATA_WIDTH-1:0]   data_readReg,
  output logic [NUM_READ-1:0]              busy_readReg,
  output logic                             status_ready,
  output logic                             status_clearDone
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastReg = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]        busy_q;

  logic wr_en;
  logic rsv_en;
  logic clr_en;

  // Writes and reserves are only honoured in IDLE; in CLEAR they are dropped outright.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
    clr_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_en  = ctrl_writeEnable && (ctrl_writeReg != '0);
        rsv_en = ctrl_reserveEnable && (ctrl_reserveReg != '0);
        if (ctrl_clear) begin
          state_d = StClear;
          ptr_d   = ADDR_WIDTH'(1);
        end
      end
      StClear: begin
        clr_en = 1'b1;
        ptr_d  = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LastReg) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  // Reserve is applied after the write so it wins when both target one register.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      for (int r = 0; r < int'(DEPTH); r++) begin
        mem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (clr_en) begin
        mem_q[ptr_q]  <= '0;
        busy_q[ptr_q] <= 1'b0;
      end
      if (wr_en) begin
        mem_q[ctrl_writeReg]  <= data_writeReg;
        busy_q[ctrl_writeReg] <= 1'b0;
      end
      if (rsv_en) begin
        busy_q[ctrl_reserveReg] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rbusy;

    assign raddr = ctrl_readReg[i*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rdata = mem_q[raddr];
      rbusy = busy_q[raddr];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (ctrl_writeReg == raddr)) begin
        rdata = data_writeReg;
        rbusy = rsv_en && (ctrl_reserveReg == raddr);
      end
`endif
      // Register 0 is hardwired regardless of what storage or bypass says.
      if (raddr == '0) begin
        rdata = '0;
        rbusy = 1'b0;
      end
    end

    assign data_readReg[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign busy_readReg[i]                          = rbusy;
  end

  assign status_ready     = (state_q == StIdle);
  assign status_clearDone = done_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed steps plus random traffic against an array-based model.
// Honours REGFILE_BYPASS_EN in the same way as the design.
module tb_regfile_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic              clock = 1'b0;
  logic              ctrl_reset_n;
  logic              ctrl_writeEnable;
  logic [AW-1:0]     ctrl_writeReg;
  logic [DW-1:0]     data_writeReg;
  logic              ctrl_reserveEnable;
  logic [AW-1:0]     ctrl_reserveReg;
  logic              ctrl_clear;
  logic [NR*AW-1:0]  ctrl_readReg;
  logic [NR*DW-1:0]  data_readReg;
  logic [NR-1:0]     busy_readReg;
  logic              status_ready;
  logic              status_clearDone;

  logic [AW-1:0]     rd_addr [NR];

  always #5 clock = ~clock;

  always_comb begin
    ctrl_readReg = '0;
    for (int i = 0; i < NR; i++) ctrl_readReg[i*AW +: AW] = rd_addr[i];
  end

  regfile_param #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_READ  (NR)
  ) dut (
    .clock             (clock),
    .ctrl_reset_n      (ctrl_reset_n),
    .ctrl_writeEnable  (ctrl_writeEnable),
    .ctrl_writeReg     (ctrl_writeReg),
    .data_writeReg     (data_writeReg),
    .ctrl_reserveEnable(ctrl_reserveEnable),
    .ctrl_reserveReg   (ctrl_reserveReg),
    .ctrl_clear        (ctrl_clear),
    .ctrl_readReg      (ctrl_readReg),
    .data_readReg      (data_readReg),
    .busy_readReg      (busy_readReg),
    .status_ready      (status_ready),
    .status_clearDone  (status_clearDone)
  );

  // Reference model: plain arrays plus a sweep position counter.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_ready;
  bit            m_done;
  int            m_sptr;

  int total = 0;
  int bad   = 0;
  int done_seen;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int a);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (m_ready && ctrl_writeEnable && int'(ctrl_writeReg) == a) return data_writeReg;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (m_ready && ctrl_writeEnable && int'(ctrl_writeReg) == a)
      return ctrl_reserveEnable && int'(ctrl_reserveReg) == a;
`endif
    return m_busy[a];
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < NR; i++) begin
      check($sformatf("p%0d_data_r%0d", i, rd_addr[i]), data_readReg[i*DW +: DW],
            exp_data(int'(rd_addr[i])));
      check($sformatf("p%0d_busy_r%0d", i, rd_addr[i]), DW'(busy_readReg[i]),
            DW'(exp_busy(int'(rd_addr[i]))));
    end
    check("ready", DW'(status_ready), DW'(m_ready));
    check("clear_done", DW'(status_clearDone), DW'(m_done));
  endtask

  task automatic model_update();
    if (!ctrl_reset_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
      m_ready = 1'b1;
      m_done  = 1'b0;
    end else if (m_ready) begin
      m_done = 1'b0;
      if (ctrl_writeEnable && ctrl_writeReg != 0) begin
        m_mem[ctrl_writeReg]  = data_writeReg;
        m_busy[ctrl_writeReg] = 1'b0;
      end
      if (ctrl_reserveEnable && ctrl_reserveReg != 0) m_busy[ctrl_reserveReg] = 1'b1;
      if (ctrl_clear) begin
        m_ready = 1'b0;
        m_sptr  = 1;
      end
    end else begin
      m_mem[m_sptr]  = '0;
      m_busy[m_sptr] = 1'b0;
      m_done = (m_sptr == DEPTH - 1);
      if (m_done) m_ready = 1'b1;
      m_sptr++;
    end
  endtask

  // One clock: check current outputs, advance the model, take the edge.
  task automatic cyc();
    #1;
    check_outputs();
    model_update();
    @(posedge clock);
    #1;
    if (status_clearDone) done_seen++;
  endtask

  task automatic idle_inputs();
    ctrl_writeEnable   = 1'b0;
    ctrl_writeReg      = '0;
    data_writeReg      = '0;
    ctrl_reserveEnable = 1'b0;
    ctrl_reserveReg    = '0;
    ctrl_clear         = 1'b0;
  endtask

  task automatic do_write(input int r, input logic [DW-1:0] v);
    idle_inputs();
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = AW'(r);
    data_writeReg    = v;
    cyc();
    idle_inputs();
  endtask

  initial begin
    for (int r = 0; r < DEPTH; r++) begin
      m_mem[r]  = 'x;
      m_busy[r] = 1'b0;
    end
    m_ready   = 1'b1;
    m_done    = 1'b0;
    m_sptr    = 0;
    done_seen = 0;
    idle_inputs();
    rd_addr[0]   = '0;
    rd_addr[1]   = '0;
    ctrl_reset_n = 1'b0;
    @(posedge clock);
    model_update();
    #1;
    ctrl_reset_n = 1'b1;

    // Random writes, then a single reset edge wipes them.
    for (int k = 0; k < 5; k++) do_write(int'($urandom_range(1, 31)), $urandom);
    ctrl_reset_n = 1'b0;
    cyc();
    ctrl_reset_n = 1'b1;
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr[0] = AW'(a);
      rd_addr[1] = AW'(a + 1);
      #1;
      check("rst_p0", data_readReg[0 +: DW], '0);
      check("rst_p1", data_readReg[DW +: DW], '0);
      check("rst_busy", DW'(busy_readReg), '0);
    end
    check("rst_ready", DW'(status_ready), DW'(1));

    // Basic write/read and register 0.
    do_write(5, 32'hDEADBEEF);
    rd_addr[0] = 5'd5;
    rd_addr[1] = 5'd5;
    #1;
    check("r5_p0", data_readReg[0 +: DW], 32'hDEADBEEF);
    check("r5_p1", data_readReg[DW +: DW], 32'hDEADBEEF);
    do_write(0, 32'h12345678);
    rd_addr[0] = 5'd0;
    #1;
    check("r0_zero", data_readReg[0 +: DW], '0);

    // Scoreboard: reserve, clear by write, write+reserve together.
    ctrl_reserveEnable = 1'b1;
    ctrl_reserveReg    = 5'd7;
    cyc();
    idle_inputs();
    rd_addr[0] = 5'd7;
    rd_addr[1] = 5'd9;
    #1;
    check("r7_reserved", DW'(busy_readReg[0]), DW'(1));
    do_write(7, 32'h55);
    #1;
    check("r7_written_busy", DW'(busy_readReg[0]), DW'(0));
    check("r7_written_data", data_readReg[0 +: DW], 32'h55);
    ctrl_writeEnable   = 1'b1;
    ctrl_writeReg      = 5'd9;
    data_writeReg      = 32'hCAFE0009;
    ctrl_reserveEnable = 1'b1;
    ctrl_reserveReg    = 5'd9;
    cyc();
    idle_inputs();
    #1;
    check("r9_data", data_readReg[DW +: DW], 32'hCAFE0009);
    check("r9_busy", DW'(busy_readReg[1]), DW'(1));

    // Full sweep with a write lost midway.
    for (int r = 1; r < DEPTH; r++) do_write(r, DW'(r));
    done_seen  = 0;
    ctrl_clear = 1'b1;
    cyc();
    ctrl_clear = 1'b0;
    for (int k = 1; k <= DEPTH - 1; k++) begin
      #1;
      check("sweep_ready_low", DW'(status_ready), DW'(0));
      if (k == 15) begin
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'd5;
        data_writeReg    = 32'hBAD0BAD0;
      end
      cyc();
      idle_inputs();
    end
    check("sweep_ready_back", DW'(status_ready), DW'(1));
    check("sweep_done_pulse", DW'(status_clearDone), DW'(1));
    cyc();
    check("sweep_done_once", DW'(done_seen), DW'(1));
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr[0] = AW'(a);
      rd_addr[1] = AW'(a + 1);
      #1;
      check("swept_p0", data_readReg[0 +: DW], '0);
      check("swept_p1", data_readReg[DW +: DW], '0);
    end

    // Reset at sweep cycle 10 aborts without a done pulse.
    for (int r = 1; r < DEPTH; r++) do_write(r, $urandom);
    done_seen  = 0;
    ctrl_clear = 1'b1;
    cyc();
    ctrl_clear = 1'b0;
    for (int k = 1; k < 10; k++) cyc();
    ctrl_reset_n = 1'b0;
    cyc();
    ctrl_reset_n = 1'b1;
    check("abort_ready", DW'(status_ready), DW'(1));
    for (int k = 0; k < 3; k++) cyc();
    check("abort_no_done", DW'(done_seen), DW'(0));

    // Same-cycle write visibility on a read port.
    do_write(3, 32'h11111111);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'hA5A5A5A5;
    rd_addr[0]       = 5'd3;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_r3", data_readReg[0 +: DW], 32'hA5A5A5A5);
`else
    check("bypass_r3", data_readReg[0 +: DW], 32'h11111111);
`endif
    cyc();
    idle_inputs();

    // Random traffic including occasional sweeps and resets.
    for (int k = 0; k < 600; k++) begin
      ctrl_writeEnable   = 1'($urandom_range(0, 1));
      ctrl_writeReg      = AW'($urandom);
      data_writeReg      = $urandom;
      ctrl_reserveEnable = 1'($urandom_range(0, 1));
      ctrl_reserveReg    = ($urandom_range(0, 3) == 0) ? ctrl_writeReg : AW'($urandom);
      ctrl_clear         = ($urandom_range(0, 40) == 0);
      ctrl_reset_n       = ($urandom_range(0, 150) != 0);
      rd_addr[0]         = AW'($urandom);
      rd_addr[1]         = ($urandom_range(0, 2) == 0) ? ctrl_writeReg : AW'($urandom);
      cyc();
    end
    ctrl_reset_n = 1'b1;
    idle_inputs();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the 32x32 two-read-port register file.
- Generalises data width, register count and read-port count.
- Adds a per-register busy scoreboard (reserve on issue, clear on writeback) and a sequential clear-sweep state machine with a ready flag.
- Sits in the processor datapath between decode/issue and writeback; register 0 is hardwired to zero.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers
NUM_READ, 2, number of independent read ports (>=1)

Ports:
clock  input  1  rising-edge clock
ctrl_reset_n  input  1  synchronous, active-low reset
ctrl_writeEnable  input  1  write strobe
ctrl_writeReg  input  ADDR_WIDTH  write address
data_writeReg  input  DATA_WIDTH  write data
ctrl_reserveEnable  input  1  mark a destination register busy
ctrl_reserveReg  input  ADDR_WIDTH  register to reserve
ctrl_clear  input  1  start clear sweep (level sampled)
ctrl_readReg  input  NUM_READ*ADDR_WIDTH  read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
data_readReg  output  NUM_READ*DATA_WIDTH  read data; port i = bits [i*DATA_WIDTH +: DATA_WIDTH]
busy_readReg  output  NUM_READ  busy bit of the register addressed on port i
status_ready  output  1  1 = IDLE, writes/reserves accepted
status_clearDone  output  1  one-cycle pulse when a sweep finishes

Behaviour:
- Reset: one clock, synchronous, active-low; reset is sampled on the rising edge of clock while ctrl_reset_n=0.
  - All registers go to 0, all busy bits to 0, state to IDLE.
  - status_ready=1, status_clearDone=0.
  - Reset overrides every other input, including an in-progress sweep.
- Register 0:
  - Always reads 0 with busy 0.
  - Writes, reserves and sweep steps to address 0 have no effect.
- Read:
  - Combinational from current storage; no same-cycle write bypass (see optional feature).
  - All NUM_READ ports are independent; any ports may address the same register.
- Write (IDLE only):
  - On a rising edge with ctrl_writeEnable=1 and ctrl_writeReg!=0: mem[ctrl_writeReg] <= data_writeReg, and busy[ctrl_writeReg] <= 0.
  - Visible on reads the following cycle.
- Reserve (IDLE only):
  - ctrl_reserveEnable=1 and ctrl_reserveReg!=0 sets busy[ctrl_reserveReg] <= 1.
  - Reserving an already-busy register leaves it busy.
- Write and reserve to the same register in the same cycle: data is written and busy ends at 1 (reserve wins).
- State machine, states IDLE and CLEAR:
  - IDLE -> CLEAR when ctrl_clear=1. ptr <= 1; status_ready <= 0 on the same edge.
  - Each CLEAR cycle: mem[ptr] <= 0, busy[ptr] <= 0, ptr <= ptr+1.
  - CLEAR -> IDLE on the edge that clears ptr = DEPTH-1. That edge also sets status_ready <= 1 and pulses status_clearDone for exactly one cycle.
  - Sweep length is DEPTH-1 clock edges (31 with defaults).
  - ctrl_clear asserted in CLEAR is ignored.
  - ctrl_clear still high on return to IDLE starts a new sweep on the next edge.
- During CLEAR:
  - ctrl_writeEnable and ctrl_reserveEnable are dropped; nothing is queued.
  - Reads return current storage, i.e. a mix of cleared and uncleared registers.
- ctrl_clear together with a write in IDLE: the write commits and the sweep starts on the same edge; the written value is later zeroed by the sweep.
- ptr is ADDR_WIDTH bits wide; it does not wrap because the sweep exits at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address equals ctrl_writeReg (non-zero), with ctrl_writeEnable=1 and status_ready=1, returns data_writeReg combinationally in the same cycle.
  - That port's busy_readReg reads 0, unless ctrl_reserveEnable targets the same register in that cycle.
- Undefined: reads return stored values only; the new value appears the cycle after the write.

Test Plan:
- Reset: hold ctrl_reset_n=0 for 1 edge after random writes -> every port reads 0x00000000, busy_readReg=0, status_ready=1.
- Write 0xDEADBEEF to r5, then read r5 on ports 0 and 1 -> both 0xDEADBEEF next cycle. Write 0x12345678 to r0 -> r0 reads 0.
- Reserve r7 -> busy=1 next cycle. Write r7=0x55 -> busy=0. Write and reserve r9 in the same cycle -> data 0x… written, busy=1.
- Fill r1..r31 with their index, pulse ctrl_clear -> status_ready=0 for 31 cycles, status_clearDone pulses once on cycle 31, all registers read 0. A write issued mid-sweep is lost.
- Assert ctrl_reset_n=0 at sweep cycle 10 -> state IDLE, status_ready=1, no status_clearDone pulse.
- REGFILE_BYPASS_EN: write r3=0xA5A5A5A5 while port 0 reads r3 -> 0xA5A5A5A5 the same cycle with the macro defined, old value without it.
